udp_tx_arbiter: RTL and testbench

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UDP TX meta/stream channel.
// Grant is registered in IDLE; meta and data are muxed combinationally from it.
module udp_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic                     udp_clk,
    input  logic                     udp_reset,

    input  logic [NUM_REQ-1:0]       s_udp_meta_valid,
    input  logic [NUM_REQ*88-1:0]    s_udp_meta_bits,
    output logic [NUM_REQ-1:0]       s_udp_meta_ready,

    input  logic [NUM_REQ-1:0]       s_data_stream_tvalid,
    input  logic [NUM_REQ-1:0]       s_data_stream_tfirst,
    input  logic [NUM_REQ-1:0]       s_data_stream_tlast,
    input  logic [NUM_REQ*256-1:0]   s_data_stream_tdata,
    input  logic [NUM_REQ*32-1:0]    s_data_stream_tkeep,
    output logic [NUM_REQ-1:0]       s_data_stream_tready,

    output logic                     m_udp_meta_valid,
    output logic [31:0]              m_udp_meta_ip_addr,
    output logic [5:0]               m_udp_meta_ip_dscp,
    output logic [1:0]               m_udp_meta_ip_ecn,
    output logic [15:0]              m_udp_meta_dst_port,
    output logic [15:0]              m_udp_meta_src_port,
    output logic [15:0]              m_udp_meta_data_len,
    input  logic                     m_udp_meta_ready,

    output logic                     m_data_stream_tvalid,
    output logic [255:0]             m_data_stream_tdata,
    output logic [31:0]              m_data_stream_tkeep,
    output logic                     m_data_stream_tfirst,
    output logic                     m_data_stream_tlast,
    input  logic                     m_data_stream_tready,

    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_active
);

    localparam int MW = 88;
    localparam int DW = 256;
    localparam int KW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_nx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_nx;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    logic [MW-1:0]    meta_slot;
    logic             in_meta;
    logic             in_data;
    logic             meta_hs;
    logic             beat_hs;

    // Folds an index in [0, 2*NUM_REQ) back into [0, NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        if (v >= NUM_REQ) begin
            return IDX_W'(v - NUM_REQ);
        end
        return IDX_W'(v);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found &&
                s_udp_meta_valid[wrap_idx(int'(rr_ptr) + k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    assign in_meta = (state == META);
    assign in_data = (state == DATA);

    assign meta_hs = m_udp_meta_valid & m_udp_meta_ready;
    assign beat_hs = m_data_stream_tvalid & m_data_stream_tready;

    always_ff @(posedge udp_clk) begin
        if (!udp_reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        rr_ptr_nx = rr_ptr;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nx = win_idx;
                    state_nx = META;
                end
            end
            META: begin
                // A dropped meta valid keeps the grant; no re-arbitration.
                if (meta_hs) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (beat_hs && m_data_stream_tlast) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = wrap_idx(int'(grant) + 1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign meta_slot = s_udp_meta_bits[grant*MW +: MW];

    assign m_udp_meta_valid    = in_meta & s_udp_meta_valid[grant];
    assign m_udp_meta_ip_addr  = meta_slot[87:56];
    assign m_udp_meta_ip_dscp  = meta_slot[55:50];
    assign m_udp_meta_ip_ecn   = meta_slot[49:48];
    assign m_udp_meta_dst_port = meta_slot[47:32];
    assign m_udp_meta_src_port = meta_slot[31:16];
    assign m_udp_meta_data_len = meta_slot[15:0];

    assign m_data_stream_tvalid = in_data & s_data_stream_tvalid[grant];
    assign m_data_stream_tdata  = s_data_stream_tdata[grant*DW +: DW];
    assign m_data_stream_tkeep  = s_data_stream_tkeep[grant*KW +: KW];
    assign m_data_stream_tfirst = s_data_stream_tfirst[grant];
    assign m_data_stream_tlast  = s_data_stream_tlast[grant];

    always_comb begin
        s_udp_meta_ready            = '0;
        s_data_stream_tready        = '0;
        s_udp_meta_ready[grant]     = in_meta & m_udp_meta_ready;
        s_data_stream_tready[grant] = in_data & m_data_stream_tready;
    end

    assign grant_idx    = grant;
    assign grant_active = (state != IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (4 requesters) with a cycle model
// of the arbitration rules and hand-computed grant/beat expectations.
module tb_udp_tx_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;

    logic             udp_clk = 1'b0;
    logic             udp_reset;
    logic [NR-1:0]    s_meta_v;
    logic [NR*88-1:0] s_meta_bits;
    logic [NR-1:0]    s_meta_rdy;
    logic [NR-1:0]    s_tv;
    logic [NR-1:0]    s_tf;
    logic [NR-1:0]    s_tl;
    logic [NR*256-1:0] s_td;
    logic [NR*32-1:0] s_tk;
    logic [NR-1:0]    s_tr;
    logic             m_mv;
    logic [31:0]      m_ip;
    logic [5:0]       m_dscp;
    logic [1:0]       m_ecn;
    logic [15:0]      m_dp;
    logic [15:0]      m_sp;
    logic [15:0]      m_len;
    logic             m_mr;
    logic             m_tv;
    logic [255:0]     m_td;
    logic [31:0]      m_tk;
    logic             m_tf;
    logic             m_tl;
    logic             m_tr;
    logic [IW-1:0]    gidx;
    logic             gact;

    udp_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW)) dut (
        .udp_clk              (udp_clk),
        .udp_reset            (udp_reset),
        .s_udp_meta_valid     (s_meta_v),
        .s_udp_meta_bits      (s_meta_bits),
        .s_udp_meta_ready     (s_meta_rdy),
        .s_data_stream_tvalid (s_tv),
        .s_data_stream_tfirst (s_tf),
        .s_data_stream_tlast  (s_tl),
        .s_data_stream_tdata  (s_td),
        .s_data_stream_tkeep  (s_tk),
        .s_data_stream_tready (s_tr),
        .m_udp_meta_valid     (m_mv),
        .m_udp_meta_ip_addr   (m_ip),
        .m_udp_meta_ip_dscp   (m_dscp),
        .m_udp_meta_ip_ecn    (m_ecn),
        .m_udp_meta_dst_port  (m_dp),
        .m_udp_meta_src_port  (m_sp),
        .m_udp_meta_data_len  (m_len),
        .m_udp_meta_ready     (m_mr),
        .m_data_stream_tvalid (m_tv),
        .m_data_stream_tdata  (m_td),
        .m_data_stream_tkeep  (m_tk),
        .m_data_stream_tfirst (m_tf),
        .m_data_stream_tlast  (m_tl),
        .m_data_stream_tready (m_tr),
        .grant_idx            (gidx),
        .grant_active         (gact)
    );

    always #5 udp_clk = ~udp_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] id;
        logic [31:0] k;
        logic        f;
        logic        l;
    } beat_t;

    beat_t bq[$];
    int    gq[$];
    int    stalls = 0;

    // model: phase 0=idle 1=meta 2=data
    int ph = 0;
    int own = 0;
    int rr = 0;
    bit live = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] one_at(input bit en, input int o,
                                             input logic b);
        logic [NR-1:0] v;
        v = '0;
        if (en) v[o] = b;
        return v;
    endfunction

    always @(posedge udp_clk) begin
        if (!udp_reset) begin
            ph   <= 0;
            rr   <= 0;
            own  <= 0;
            live <= 1'b1;
        end else if (live) begin
            if (ph == 0) begin
                if (pick(rr, s_meta_v) >= 0) begin
                    own <= pick(rr, s_meta_v);
                    ph  <= 1;
                end
            end else if (ph == 1) begin
                if (s_meta_v[own] && m_mr) ph <= 2;
            end else if (s_tv[own] && m_tr && s_tl[own]) begin
                ph <= 0;
                rr <= (own + 1) % NR;
            end
        end
    end

    always @(negedge udp_clk) begin
        if (m_mv && m_mr) gq.push_back(int'(gidx));
        if (m_tv && m_tr) bq.push_back('{m_td[255:232], m_tk, m_tf, m_tl});
        if (m_tv && !m_tr) stalls++;
        if (live) begin
            chk("meta_valid", m_mv, (ph == 1) && s_meta_v[own]);
            chk("data_valid", m_tv, (ph == 2) && s_tv[own]);
            chk("meta_ready", s_meta_rdy, one_at(ph == 1, own, m_mr));
            chk("data_ready", s_tr, one_at(ph == 2, own, m_tr));
            chk("active", gact, ph != 0);
            if (ph != 0) chk("grant", gidx, own);
            if (ph == 1 && s_meta_v[own])
                chk("meta_fields",
                    {m_ip, m_dscp, m_ecn, m_dp, m_sp, m_len},
                    s_meta_bits[88*own +: 88]);
            if (ph == 2 && s_tv[own]) begin
                chk("tdata", m_td, s_td[256*own +: 256]);
                chk("tctl", {m_tk, m_tf, m_tl},
                    {s_tk[32*own +: 32], s_tf[own], s_tl[own]});
            end
        end
    end

    task automatic step();
        @(posedge udp_clk);
        #1;
    endtask

    task automatic wait_rdy(input int r, input bit is_meta,
                            input string nm);
        int t = 0;
        bit hs = 1'b0;
        while (!hs && t < 200) begin
            @(negedge udp_clk);
            hs = is_meta ? s_meta_rdy[r] : s_tr[r];
            step();
            t++;
        end
        chk(nm, hs, 1'b1);
    endtask

    task automatic put_meta(input int r, input int nb,
                            input logic [15:0] dp, input logic [7:0] tag);
        s_meta_bits[88*r +: 88] = {24'hC0A801, tag, 6'(r + 1), 2'(r),
                                   dp, 16'(32'h1000 + r), 16'(nb * 32)};
    endtask

    task automatic put_beat(input int r, input int b, input int nb,
                            input logic [7:0] tag, input logic [31:0] kl);
        s_td[256*r +: 256] = {8'(r), tag, 8'(b), {29{8'hA5}}};
        s_tk[32*r +: 32]   = (b == nb - 1) ? kl : 32'hFFFF_FFFF;
        s_tf[r] = (b == 0);
        s_tl[r] = (b == nb - 1);
        s_tv[r] = 1'b1;
    endtask

    task automatic send_pkt(input int r, input int nb,
                            input logic [15:0] dp, input logic [7:0] tag,
                            input logic [31:0] kl);
        put_meta(r, nb, dp, tag);
        s_meta_v[r] = 1'b1;
        wait_rdy(r, 1'b1, "meta_hs");
        s_meta_v[r] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            put_beat(r, b, nb, tag, kl);
            wait_rdy(r, 1'b0, "beat_hs");
        end
        s_tv[r] = 1'b0;
        s_tf[r] = 1'b0;
        s_tl[r] = 1'b0;
    endtask

    initial begin
        udp_reset   = 1'b0;
        s_meta_v    = '0;
        s_meta_bits = '0;
        s_tv        = '0;
        s_tf        = '0;
        s_tl        = '0;
        s_td        = '0;
        s_tk        = '0;
        m_mr        = 1'b1;
        m_tr        = 1'b1;
        repeat (3) step();
        @(negedge udp_clk);
        chk("rst_valids", {m_mv, m_tv}, 2'b00);
        chk("rst_readies", {s_meta_rdy, s_tr}, 8'h00);
        chk("rst_grant", {gact, gidx}, 3'b000);
        step();
        udp_reset = 1'b1;
        step();

        // single 2-beat packet from req0, meta latency one cycle
        gq.delete();
        bq.delete();
        fork
            send_pkt(0, 2, 16'h1234, 8'h01, 32'hFFFF_FFFF);
            begin
                @(negedge udp_clk);
                chk("lat_idle", m_mv, 1'b0);
                @(negedge udp_clk);
                chk("lat_meta", m_mv, 1'b1);
                chk("dst_port", m_dp, 16'h1234);
                chk("data_len", m_len, 16'd64);
            end
        join
        @(negedge udp_clk);
        chk("p0_idle", gact, 1'b0);
        chk("p0_beats", bq.size(), 2);
        if (bq.size() == 2) begin
            chk("p0_b0", bq[0].id, 24'h000100);
            chk("p0_b1", {bq[1].id, bq[1].l}, {24'h000101, 1'b1});
        end
        step();

        // rr_ptr now 1: req1 must win a simultaneous request
        gq.delete();
        fork
            send_pkt(0, 1, 16'h0020, 8'h20, 32'hFFFF_FFFF);
            send_pkt(1, 1, 16'h0021, 8'h21, 32'hFFFF_FFFF);
        join
        chk("rr1_order", {gq.size(), gq.size() == 2 ? gq[0] : -1},
            {32'd2, 32'd1});

        // single-beat packet from req1 with partial keep
        gq.delete();
        bq.delete();
        send_pkt(1, 1, 16'h0031, 8'h31, 32'h0000_000F);
        @(negedge udp_clk);
        chk("sb_idle", gact, 1'b0);
        chk("sb_beats", bq.size(), 1);
        if (bq.size() == 1)
            chk("sb_ctl", {bq[0].k, bq[0].f, bq[0].l},
                {32'h0000_000F, 2'b11});
        step();

        // both requesters streaming 3 packets each (rr_ptr = 2)
        gq.delete();
        bq.delete();
        fork
            for (int i = 0; i < 3; i++)
                send_pkt(0, 2, 16'h4000, 8'(8'h40 + i), 32'hFFFF_FFFF);
            for (int i = 0; i < 3; i++)
                send_pkt(1, 2, 16'h5000, 8'(8'h50 + i), 32'hFFFF_FFFF);
        join
        chk("alt_cnt", gq.size(), 6);
        chk("alt_beats", bq.size(), 12);
        if (gq.size() == 6 && bq.size() == 12) begin
            for (int i = 0; i < 6; i++)
                chk("alt_grant", gq[i], i % 2);
            for (int i = 0; i < 12; i++)
                chk("alt_owner", bq[i].id[23:16], (i / 2) % 2);
        end

        // 4-beat packet with toggling downstream ready
        bq.delete();
        stalls = 0;
        fork
            send_pkt(0, 4, 16'h3000, 8'h30, 32'hFFFF_FFFF);
            repeat (16) begin
                m_tr = ~m_tr;
                step();
            end
        join
        m_tr = 1'b1;
        chk("stall_beats", bq.size(), 4);
        chk("stall_seen", stalls > 0, 1'b1);
        if (bq.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("stall_order", bq[i].id, {16'h0030, 8'(i)});

        // reset during beat 2 of 4
        bq.delete();
        put_meta(0, 4, 16'h0032, 8'h32);
        s_meta_v[0] = 1'b1;
        wait_rdy(0, 1'b1, "rst_meta_hs");
        s_meta_v[0] = 1'b0;
        put_beat(0, 0, 4, 8'h32, 32'hFFFF_FFFF);
        wait_rdy(0, 1'b0, "rst_b0_hs");
        put_beat(0, 1, 4, 8'h32, 32'hFFFF_FFFF);
        udp_reset = 1'b0;
        step();
        @(negedge udp_clk);
        chk("mid_rst_out", {m_mv, m_tv, gact, s_meta_rdy, s_tr},
            11'd0);
        chk("mid_rst_beats", bq.size(), 2);
        step();
        udp_reset = 1'b1;
        put_beat(0, 2, 4, 8'h32, 32'hFFFF_FFFF);
        repeat (6) step();
        chk("rst_no_fwd", bq.size(), 2);
        s_tv[0] = 1'b0;
        s_tf[0] = 1'b0;
        s_tl[0] = 1'b0;
        step();

        // req3 alone from rr_ptr 0, then wrap back to 0
        gq.delete();
        send_pkt(3, 2, 16'h0033, 8'h33, 32'hFFFF_FFFF);
        chk("req3_grant", {gq.size(), gq.size() == 1 ? gq[0] : -1},
            {32'd1, 32'd3});
        gq.delete();
        fork
            send_pkt(0, 1, 16'h0034, 8'h34, 32'hFFFF_FFFF);
            send_pkt(3, 1, 16'h0035, 8'h35, 32'hFFFF_FFFF);
        join
        chk("wrap_order", {gq.size(), gq.size() == 2 ? gq[0] : -1},
            {32'd2, 32'd0});

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
